// File: rtl/simp_pkg.sv
// Shared types and constants for the unified-memory sequencer.
//   umem_state_e : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   req_id_e     : requester identity; the value doubles as the bit index
//                  of that requester in the arbiter's req vector
//   MEM_RD/MEM_WR: encodings of the memory read/write strobe
package simp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } umem_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LSU   = 1'b1
  } req_id_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // Word accesses only: any nonzero byte offset is a misaligned LSU access.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  : request vector, indexed by req_id_e (bit 0 fetch, bit 1 LSU)
//   last      : requester granted most recently
//   gnt_id    : chosen requester (meaningful only when gnt_valid)
//   gnt_valid : at least one request is present
// A lone requester always wins; when both request, the one that was not
// granted last wins.
import simp_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  req_id_e    last,
  output req_id_e    gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_FETCH;
    case (req)
      2'b01:   gnt_id = REQ_FETCH;
      2'b10:   gnt_id = REQ_LSU;
      2'b11:   gnt_id = (last == REQ_FETCH) ? REQ_LSU : REQ_FETCH;
      default: gnt_id = REQ_FETCH;
    endcase
  end

endmodule

// File: rtl/umem_arbiter.sv
// Sequencer and two-way arbiter for the single-port unified memory.
// Shares the memory between instruction fetch (read-only) and load/store.
// One access at a time runs through IDLE -> ACCESS -> RESP.
//
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   f_req/f_addr          : fetch request (level) and byte address
//   f_ack/f_rdata         : fetch completion pulse and read data
//   l_req/l_we/l_addr/l_wdata : load/store request, write flag, address, data
//   l_ack/l_rdata/l_err   : load/store completion pulse, load data, misalign error
//   mem_addr/mem_wdata/mem_rw : registered memory inputs (rw: 1 write, 0 read)
//   mem_rdata             : memory read data, valid one cycle after address
//   busy                  : sequencer not in IDLE
//
// Handshake: a requester raises req and holds it and its operands stable
// until it sees its ack pulse; it drops req (or presents the next request)
// on the clock edge that ends the ack cycle. req is looked at only in IDLE,
// and operands are captured only on the IDLE->ACCESS edge. ack is high for
// exactly one cycle (RESP) and rdata/l_err are valid in that cycle.
import simp_pkg::*;

module umem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic          l_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  umem_state_e   state_q, state_d;
  req_id_e       last_q;
  req_id_e       win_q;
  req_id_e       gnt_id;
  logic          gnt_valid;
  logic          we_q;
  logic          err_q;
  logic          l_mis;
  logic [DW-1:0] f_rdata_q;
  logic [DW-1:0] l_rdata_q;

  // Fetch addresses are forced word-aligned, so the byte offset is unused.
  logic          unused_f_lo;
  assign unused_f_lo = ^f_addr[1:0];

  assign l_mis = is_misaligned(l_addr[1:0]);

  rr_arb2 u_rr_arb2 (
    .req       ({l_req, f_req}),
    .last      (last_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt_valid ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // Read data is passed straight through from memory during the ack cycle
  // (the memory delivers it in RESP) and held from the registers otherwise.
  // Stores and misaligned loads leave l_rdata untouched.
  // ---------------------------------------------------------------------
  always_comb begin
    busy    = (state_q != IDLE);
    f_ack   = (state_q == RESP) && (win_q == REQ_FETCH);
    l_ack   = (state_q == RESP) && (win_q == REQ_LSU);
    l_err   = l_ack && err_q;
    f_rdata = f_ack ? mem_rdata : f_rdata_q;
    l_rdata = (l_ack && !we_q && !err_q) ? mem_rdata : l_rdata_q;
  end

  // ---------------------------------------------------------------------
  // Datapath registers: winner, memory command, round-robin pointer,
  // held read data.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= REQ_LSU;
      win_q     <= REQ_FETCH;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= MEM_RD;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            win_q <= gnt_id;
            if (gnt_id == REQ_FETCH) begin
              mem_addr  <= {f_addr[AW-1:2], 2'b00};
              mem_wdata <= '0;
              mem_rw    <= MEM_RD;
              we_q      <= 1'b0;
              err_q     <= 1'b0;
            end else begin
              mem_addr  <= l_addr;
              mem_wdata <= l_wdata;
              we_q      <= l_we;
              err_q     <= l_mis;
              // A misaligned access becomes a discarded read so memory is
              // never written with it.
              mem_rw    <= (l_we && !l_mis) ? MEM_WR : MEM_RD;
            end
          end else begin
            mem_rw <= MEM_RD;
          end
        end
        ACCESS: begin
          // The write strobe lasts exactly the one ACCESS cycle.
          mem_rw <= MEM_RD;
        end
        RESP: begin
          last_q <= win_q;
          if (win_q == REQ_FETCH) begin
            f_rdata_q <= mem_rdata;
          end else if (!we_q && !err_q) begin
            l_rdata_q <= mem_rdata;
          end
        end
        default: begin
          mem_rw <= MEM_RD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// Testbench for umem_arbiter: directed scenarios followed by randomized
// traffic from both requesters, checked every cycle against a
// transaction-level model (grant rule, 3-cycle access, reference memory).
module tb_umem_arbiter;

  // -------------------------------------------------------------------
  // clock / reset / DUT
  // -------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_ack;
  logic [31:0] l_rdata;
  logic        l_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  umem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_ack     (l_ack),
    .l_rdata   (l_rdata),
    .l_err     (l_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous single-port memory: data valid one cycle after address.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr[5:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[5:2]];
  end

  // -------------------------------------------------------------------
  // scoreboard
  // -------------------------------------------------------------------
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 memory access, 2 response.
  int          ph;
  logic        m_last;   // 0 fetch, 1 lsu
  logic        m_win;
  logic        m_we;
  logic        m_mis;
  logic [3:0]  m_idx;
  logic [31:0] m_wdata;
  logic [31:0] ref_mem [16];
  logic [31:0] e_f_rdata;
  logic [31:0] e_l_rdata;
  logic        e_f_ack;
  logic        e_l_ack;
  logic        e_rw;
  logic        f_done;
  logic        l_done;

  logic [31:0] exp_q[$];  // expected grant order in the round-robin scenario
  logic [31:0] obs_q[$];  // observed ack order
  int          obs_cyc[$];
  int          cyc;
  int          wr_cnt;
  logic        err_seen;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      ph = 0; m_last = 1'b1; e_f_rdata = '0; e_l_rdata = '0;
      f_done = 1'b0; l_done = 1'b0;
    end
    e_f_ack = (ph == 2) && !m_win;
    e_l_ack = (ph == 2) && m_win;
    e_rw    = (ph == 1) && m_win && m_we && !m_mis;
    if (ph == 2) begin
      if (!m_win) e_f_rdata = ref_mem[m_idx];
      else if (!m_we && !m_mis) e_l_rdata = ref_mem[m_idx];
    end
    chk("f_ack",   {31'd0, f_ack},  {31'd0, e_f_ack});
    chk("l_ack",   {31'd0, l_ack},  {31'd0, e_l_ack});
    chk("l_err",   {31'd0, l_err},  {31'd0, e_l_ack && m_mis});
    chk("mem_rw",  {31'd0, mem_rw}, {31'd0, e_rw});
    chk("busy",    {31'd0, busy},   {31'd0, ph != 0});
    chk("f_rdata", f_rdata, e_f_rdata);
    chk("l_rdata", l_rdata, e_l_rdata);
    if (reset) begin
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end
    if (ph == 1 && !m_mis) chk("mem_addr", mem_addr, {26'd0, m_idx, 2'b00});
    if (e_rw) chk("mem_wdata", mem_wdata, m_wdata);

    if (f_ack) begin obs_q.push_back(32'd0); obs_cyc.push_back(cyc); end
    if (l_ack) begin obs_q.push_back(32'd1); obs_cyc.push_back(cyc); end
    if (l_ack && l_err) err_seen = 1'b1;
    if (mem_rw) wr_cnt++;

    if (!reset) begin
      case (ph)
        0: if (f_req || l_req) begin
          m_win = (f_req && l_req) ? ~m_last : l_req;
          if (!m_win) begin
            m_idx = f_addr[5:2]; m_we = 1'b0; m_mis = 1'b0;
          end else begin
            m_idx = l_addr[5:2]; m_we = l_we; m_mis = (l_addr[1:0] != 2'b00);
            m_wdata = l_wdata;
          end
          ph = 1;
        end
        1: begin
          if (m_win && m_we && !m_mis) ref_mem[m_idx] = m_wdata;
          ph = 2;
        end
        default: begin
          m_last = m_win;
          if (m_win) l_done = 1'b1; else f_done = 1'b1;
          ph = 0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------
  task automatic wait_done(input logic who);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (!who && f_done) begin f_done = 1'b0; f_req = 1'b0; got = 1'b1; end
      if (who && l_done)  begin l_done = 1'b0; l_req = 1'b0; got = 1'b1; end
    end
    chk("ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = a;
    wait_done(1'b0);
  endtask

  task automatic do_lsu(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
    wait_done(1'b1);
  endtask

  task automatic rand_step(input logic allow_new);
    if (f_done) begin f_done = 1'b0; f_req = 1'b0; end
    if (l_done) begin l_done = 1'b0; l_req = 1'b0; end
    if (allow_new && !f_req && $urandom_range(0, 2) != 0) begin
      f_req  = 1'b1;
      f_addr = $urandom_range(0, 63);
    end
    if (allow_new && !l_req && $urandom_range(0, 2) != 0) begin
      l_req   = 1'b1;
      l_we    = $urandom_range(0, 1);
      l_addr  = {26'd0, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      l_wdata = $urandom;
    end
  endtask

  // -------------------------------------------------------------------
  // main sequence
  // -------------------------------------------------------------------
  logic [31:0] saved;
  int          w0;
  logic        idle_ok;

  initial begin
    clk = 1'b0; reset = 1'b1;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    n_cmp = 0; n_bad = 0; cyc = 0; wr_cnt = 0; err_seen = 1'b0;
    ph = 0; m_last = 1'b1; m_win = 1'b0; m_we = 1'b0; m_mis = 1'b0; m_idx = '0; m_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single fetch from 0x10
    do_fetch(32'h10);
    chk("fetch_rdata", f_rdata, 32'hDEADBEEF);

    // store then load back from 0x20
    w0 = wr_cnt;
    do_lsu(1'b1, 32'h20, 32'h12345678);
    do_lsu(1'b0, 32'h20, 32'h0);
    chk("store_write_count", wr_cnt - w0, 32'd1);
    chk("load_back", l_rdata, 32'h12345678);

    // misaligned load
    w0 = wr_cnt;
    do_lsu(1'b0, 32'h22, 32'h0);
    chk("mis_err_seen", {31'd0, err_seen}, 32'd1);
    chk("mis_l_rdata", l_rdata, 32'h12345678);
    chk("mis_no_write", wr_cnt - w0, 32'd0);

    // both requesting continuously after reset: F, L, F, L every 3 cycles
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete();
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    f_addr = 32'h4; l_addr = 32'h8; l_we = 1'b0;
    f_req = 1'b1; l_req = 1'b1; reset = 1'b0;
    for (int i = 0; i < 30 && obs_q.size() < 4; i++) begin
      @(posedge clk); #1;
      f_done = 1'b0; l_done = 1'b0;
    end
    f_req = 1'b0; l_req = 1'b0;
    chk("rr_ack_count", obs_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("rr_order", obs_q[i], exp_q[i]);
      if (i > 0) chk("rr_spacing", obs_cyc[i] - obs_cyc[i-1], 32'd3);
    end
    repeat (2) @(posedge clk);

    // reset during the ACCESS cycle of a store
    saved = mem[8];
    @(posedge clk); #1;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;   // now in ACCESS
    reset = 1'b1;
    @(posedge clk); #1;
    l_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_store_dropped", mem[8], saved);
    do_fetch(32'h20);
    chk("post_rst_fetch", f_rdata, saved);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rand_step(1'b1);
    end
    idle_ok = 1'b0;
    for (int i = 0; i < 40 && !idle_ok; i++) begin
      @(posedge clk); #1;
      rand_step(1'b0);
      idle_ok = !f_req && !l_req && (ph == 0);
    end
    chk("drain_idle", {31'd0, idle_ok}, 32'd1);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Sequencer and two-way arbiter for the single-port unified data memory (`umem` port: `mem_addr`, `mem_wdata`, `mem_rw`, `mem_rdata`). The block shares the memory between the instruction-fetch requester (read-only) and the load/store requester (read/write). It runs one access at a time through a fixed three-state sequence and returns read data with a one-cycle `ack` pulse. It sits between the core's fetch/LSU logic and the memory, and is the only driver of the memory's inputs.

## Interface
- `AW`, default 32: address width (byte address).
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `f_req`  in  1  fetch request, level, held until `f_ack`.
- `f_addr`  in  AW  fetch byte address, stable while `f_req`.
- `f_ack`  out  1  one-cycle completion pulse for fetch.
- `f_rdata`  out  DW  fetch read data, valid when `f_ack`.
- `l_req`  in  1  load/store request, level, held until `l_ack`.
- `l_we`  in  1  1 = store, 0 = load.
- `l_addr`  in  AW  load/store byte address.
- `l_wdata`  in  DW  store data.
- `l_ack`  out  1  one-cycle completion pulse for load/store.
- `l_rdata`  out  DW  load data, valid when `l_ack` and `l_we` = 0.
- `l_err`  out  1  valid with `l_ack`; 1 = misaligned address, access not performed.
- `mem_addr`  out  AW  memory address (registered).
- `mem_wdata`  out  DW  memory write data (registered).
- `mem_rw`  out  1  1 = write, 0 = read (registered).
- `mem_rdata`  in  DW  memory read data, valid one cycle after address presented.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req` high, pick winner via round-robin; latch winner ID, address, wdata, write flag into `mem_*` registers; go ACCESS. No request: stay IDLE, `mem_rw` held 0.
- Round-robin: one `last` bit. Both requesting -> grant the one not granted last. Only one requesting -> grant it. Reset value of `last` = LSU, so first contested grant goes to fetch.
- Misaligned LSU address (`l_addr[1:0]` != 0): winner latched, `mem_rw` forced 0 (read, discarded); RESP asserts `l_ack` with `l_err` = 1. Fetch addresses are not checked; `f_addr[1:0]` are ignored and the address is used word-aligned.
- ACCESS: memory samples `mem_*`; `mem_rw` deasserted to 0 at exit; go RESP.
- RESP: register `mem_rdata` into winner's `rdata`; pulse winner's `ack` for exactly one cycle; update `last`; go IDLE.
- `f_rdata`/`l_rdata` hold last value between acks. Store ack: `l_rdata` unchanged.

## Timing
- `req` high in IDLE cycle N -> `mem_*` valid cycle N+1 -> `ack` high cycle N+2 -> IDLE cycle N+3. Access period 3 cycles; reads and writes identical.
- Requester drops `req` (or presents next request) on the edge ending the `ack` cycle; a `req` seen in cycle N+3 is a new request.
- `req` is sampled only in IDLE; changes during ACCESS/RESP are ignored. Inputs are captured only at the IDLE->ACCESS edge.
- Exactly one memory write per store, asserted for the single ACCESS cycle.
- Reset (any state, any cycle): state IDLE, `last` = LSU, `f_ack` = `l_ack` = `l_err` = 0, `mem_rw` = 0, `mem_addr` = `mem_wdata` = 0, `f_rdata` = `l_rdata` = 0, `busy` = 0. An in-flight access is abandoned with no ack. A store interrupted before ACCESS is never written.

## Structure
- Shared package `simp_pkg`: `umem_state_e` (IDLE, ACCESS, RESP), `req_id_e` (REQ_FETCH, REQ_LSU), constants `MEM_RD` = 0 and `MEM_WR` = 1.
- Sub-module `rr_arb2`: combinational two-way round-robin picker (inputs `req[1:0]`, `last`; output `gnt_id`, `gnt_valid`). The FSM and datapath registers live in `umem_arbiter`.

## Test plan
- Single fetch, `f_addr` = 0x10, memory word 0x10 = 0xDEADBEEF -> `f_ack` at N+2 with `f_rdata` = 0xDEADBEEF; `l_ack` stays 0; `mem_rw` = 0 throughout.
- Store `l_addr` = 0x20, `l_wdata` = 0x12345678, then a load from 0x20 -> exactly one `mem_rw` = 1 cycle; load ack returns 0x12345678 with `l_err` = 0.
- `f_req` and `l_req` held high together for 4 accesses after reset -> grants in order F, L, F, L, with acks at 3-cycle spacing.
- Misaligned load `l_addr` = 0x22 -> `l_ack` with `l_err` = 1; no memory write; `l_rdata` unchanged.
- `reset` asserted during ACCESS of a store -> no ack; all outputs at reset values the same cycle; at most the single ACCESS-cycle write occurs; next request after release completes normally.
